// File: rtl/stream_pack2_tx_if.sv
// Handshake bundle for stream_pack2_tx: two kernel-side input streams and the
// packed LII output lane with its constant routing tags.
interface stream_pack2_tx_if #(
    parameter int PW = 128,
    parameter int W0 = 56,
    parameter int W1 = 58
);
    logic [W0-1:0] s0_tdata;
    logic          s0_tvalid;
    logic          s0_tready;

    logic [W1-1:0] s1_tdata;
    logic          s1_tvalid;
    logic          s1_tready;

    logic [PW-1:0] lii_out_p0_tdata;
    logic          lii_out_p0_tvalid;
    logic          lii_out_p0_tready;
    logic [7:0]    lii_out_p0_src;
    logic [7:0]    lii_out_p0_dst;

    // Kernel/sink side: produces the streams, consumes the LII lane.
    modport master (
        output s0_tdata, s0_tvalid,
        input  s0_tready,
        output s1_tdata, s1_tvalid,
        input  s1_tready,
        input  lii_out_p0_tdata, lii_out_p0_tvalid,
        output lii_out_p0_tready,
        input  lii_out_p0_src, lii_out_p0_dst
    );

    // Packer side.
    modport slave (
        input  s0_tdata, s0_tvalid,
        output s0_tready,
        input  s1_tdata, s1_tvalid,
        output s1_tready,
        output lii_out_p0_tdata, lii_out_p0_tvalid,
        input  lii_out_p0_tready,
        output lii_out_p0_src, lii_out_p0_dst
    );
endinterface

// File: rtl/stream_pack2_tx.sv
// Packs one beat from each of two independent logic streams into a single
// zero-padded LII beat; one holding register per stream, registered output.
module stream_pack2_tx #(
    parameter int           PW     = 128,
    parameter int           W0     = 56,
    parameter int           W1     = 58,
    parameter logic [7:0]   SRC_ID = 8'h00,
    parameter logic [7:0]   DST_ID = 8'h01
) (
    input  logic        aclk,
    input  logic        arst,
    stream_pack2_tx_if.slave bus,
    output logic [31:0] beat_cnt,
    output logic        ce
);
    localparam int PACKW = W0 + W1;

    generate
        if (PACKW > PW) begin : g_width_check
            $error("stream_pack2_tx: W0+W1 exceeds PW");
        end
    endgenerate

    logic          full0_q, full0_d;
    logic          full1_q, full1_d;
    logic [W0-1:0] hold0_q, hold0_d;
    logic [W1-1:0] hold1_q, hold1_d;
    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] out_data_q, out_data_d;
    logic [31:0]   beat_cnt_q, beat_cnt_d;

    logic          pack;
    logic          s0_rdy, s1_rdy;
    logic          hs0, hs1, out_hs;
    logic [PW-1:0] pack_word;

    always_comb begin
        pack      = full0_q & full1_q & (~out_valid_q | bus.lii_out_p0_tready);
        // Readies are forced low during reset so nothing is accepted then.
        s0_rdy    = ~arst & (~full0_q | pack);
        s1_rdy    = ~arst & (~full1_q | pack);
        hs0       = bus.s0_tvalid & s0_rdy;
        hs1       = bus.s1_tvalid & s1_rdy;
        out_hs    = out_valid_q & bus.lii_out_p0_tready;

        pack_word = '0;
        pack_word[W0-1:0]    = hold0_q;
        pack_word[PACKW-1:W0] = hold1_q;

        // A reload in the same cycle as a pack keeps the register full.
        full0_d = hs0 ? 1'b1 : (pack ? 1'b0 : full0_q);
        full1_d = hs1 ? 1'b1 : (pack ? 1'b0 : full1_q);
        hold0_d = hs0 ? bus.s0_tdata : hold0_q;
        hold1_d = hs1 ? bus.s1_tdata : hold1_q;

        out_valid_d = pack ? 1'b1 : (out_hs ? 1'b0 : out_valid_q);
        out_data_d  = pack ? pack_word : out_data_q;
        beat_cnt_d  = out_hs ? beat_cnt_q + 32'd1 : beat_cnt_q;
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            full0_q     <= 1'b0;
            full1_q     <= 1'b0;
            hold0_q     <= '0;
            hold1_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            beat_cnt_q  <= 32'd0;
        end else begin
            full0_q     <= full0_d;
            full1_q     <= full1_d;
            hold0_q     <= hold0_d;
            hold1_q     <= hold1_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign bus.s0_tready         = s0_rdy;
    assign bus.s1_tready         = s1_rdy;
    assign bus.lii_out_p0_tdata  = out_data_q;
    assign bus.lii_out_p0_tvalid = out_valid_q;
    assign bus.lii_out_p0_src    = SRC_ID;
    assign bus.lii_out_p0_dst    = DST_ID;
    assign beat_cnt              = beat_cnt_q;
    assign ce                    = s0_rdy & s1_rdy;
endmodule

// File: tb/tb_stream_pack2_tx.sv
// Scoreboard bench for stream_pack2_tx: directed stimulus pushes expected LII
// beats into a queue, an independent monitor pops and compares each handshake.
module tb_stream_pack2_tx;
    localparam int PW = 128;
    localparam int W0 = 56;
    localparam int W1 = 58;
    localparam int LIMIT = 2000;

    typedef struct {
        logic [63:0] data;
        int          gap;
    } item_t;

    logic        aclk = 1'b0;
    logic        arst = 1'b1;
    logic [31:0] beat_cnt;
    logic        ce;

    stream_pack2_tx_if #(.PW(PW), .W0(W0), .W1(W1)) bus ();

    stream_pack2_tx #(.PW(PW), .W0(W0), .W1(W1), .SRC_ID(8'h00), .DST_ID(8'h01)) dut (
        .aclk     (aclk),
        .arst     (arst),
        .bus      (bus),
        .beat_cnt (beat_cnt),
        .ce       (ce)
    );

    always #5 aclk = ~aclk;

    item_t          q0[$];
    item_t          q1[$];
    logic [PW-1:0]  exp_q[$];
    int             n_checks = 0;
    int             n_fail   = 0;
    int             n_beats  = 0;
    logic           rnd_rdy  = 1'b0;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [63:0] d0, input logic [63:0] d1);
        logic [PW-1:0] e;
        e = '0;
        e[W0-1:0]     = d0[W0-1:0];
        e[W0+W1-1:W0] = d1[W1-1:0];
        exp_q.push_back(e);
    endtask

    task automatic add_pair(input logic [63:0] d0, input logic [63:0] d1, input int g0, input int g1);
        item_t a;
        item_t b;
        a.data = d0; a.gap = g0;
        b.data = d1; b.gap = g1;
        q0.push_back(a);
        q1.push_back(b);
        push_exp(d0, d1);
    endtask

    // Drivers expect to be entered just after a rising edge.
    task automatic drive0();
        item_t it;
        logic  acc;
        int    t;
        while (q0.size() > 0) begin
            it = q0.pop_front();
            repeat (it.gap) begin @(posedge aclk); #1; end
            bus.s0_tdata  = it.data[W0-1:0];
            bus.s0_tvalid = 1'b1;
            t = 0;
            do begin
                @(negedge aclk); acc = bus.s0_tready;
                @(posedge aclk); #1; t++;
            end while (!acc && t < LIMIT);
            bus.s0_tvalid = 1'b0;
            if (!acc) begin
                n_checks++; n_fail++;
                $display("FAIL s0_accept_timeout: got no s0_tready required s0_tready=1");
            end
        end
    endtask

    task automatic drive1();
        item_t it;
        logic  acc;
        int    t;
        while (q1.size() > 0) begin
            it = q1.pop_front();
            repeat (it.gap) begin @(posedge aclk); #1; end
            bus.s1_tdata  = it.data[W1-1:0];
            bus.s1_tvalid = 1'b1;
            t = 0;
            do begin
                @(negedge aclk); acc = bus.s1_tready;
                @(posedge aclk); #1; t++;
            end while (!acc && t < LIMIT);
            bus.s1_tvalid = 1'b0;
            if (!acc) begin
                n_checks++; n_fail++;
                $display("FAIL s1_accept_timeout: got no s1_tready required s1_tready=1");
            end
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < LIMIT) begin @(posedge aclk); #1; t++; end
        check("drain", PW'(exp_q.size()), '0);
    endtask

    // Monitor: every completed output handshake is compared with the scoreboard.
    always @(negedge aclk) begin
        if (!arst && bus.lii_out_p0_tvalid && bus.lii_out_p0_tready) begin
            n_beats++;
            $display("beat %0d data %h", n_beats, bus.lii_out_p0_tdata);
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_beat: got %h required no beat", bus.lii_out_p0_tdata);
            end else begin
                check("beat_data", bus.lii_out_p0_tdata, exp_q.pop_front());
            end
        end
    end

    always @(posedge aclk) begin
        #1;
        if (rnd_rdy) bus.lii_out_p0_tready = ($urandom_range(0, 3) != 0);
    end

    int hs;

    initial begin
        bus.s0_tdata = '0; bus.s0_tvalid = 1'b0;
        bus.s1_tdata = '0; bus.s1_tvalid = 1'b0;
        bus.lii_out_p0_tready = 1'b1;

        // Reset state
        repeat (3) @(negedge aclk);
        check("rst_s0_tready", PW'(bus.s0_tready), '0);
        check("rst_s1_tready", PW'(bus.s1_tready), '0);
        check("rst_ce", PW'(ce), '0);
        check("rst_tvalid", PW'(bus.lii_out_p0_tvalid), '0);
        check("rst_beat_cnt", PW'(beat_cnt), '0);
        check("rst_tdata", bus.lii_out_p0_tdata, '0);
        check("src", PW'(bus.lii_out_p0_src), PW'(8'h00));
        check("dst", PW'(bus.lii_out_p0_dst), PW'(8'h01));
        arst = 1'b0;
        @(posedge aclk); #1;
        check("idle_ce", PW'(ce), PW'(1'b1));

        // Both streams same cycle: s1 lands at bit 56, beat visible two edges later
        exp_q.push_back(128'h2_00000000000001);
        bus.s0_tdata = 56'h1; bus.s0_tvalid = 1'b1;
        bus.s1_tdata = 58'h2; bus.s1_tvalid = 1'b1;
        @(posedge aclk); #1;
        bus.s0_tvalid = 1'b0; bus.s1_tvalid = 1'b0;
        check("lat_not_early", PW'(bus.lii_out_p0_tvalid), '0);
        @(posedge aclk); #1;
        check("lat_tvalid", PW'(bus.lii_out_p0_tvalid), PW'(1'b1));
        check("lat_tdata", bus.lii_out_p0_tdata, 128'h2_00000000000001);
        @(posedge aclk); #1;
        check("beat_cnt_1", PW'(beat_cnt), PW'(32'd1));
        check("tvalid_clear", PW'(bus.lii_out_p0_tvalid), '0);

        // s0 waits for a late s1; pack and reload of s0 in the same cycle
        push_exp(64'hAAAA_0000_0000_01, 64'h0CCC_0000_0000_0003);
        push_exp(64'hBBBB_0000_0000_02, 64'h0DDD_0000_0000_0004);
        bus.s0_tdata = 56'hAAAA_0000_0000_01; bus.s0_tvalid = 1'b1;
        @(posedge aclk); #1;
        bus.s0_tdata = 56'hBBBB_0000_0000_02;
        for (int i = 1; i < 10; i++) begin
            @(negedge aclk);
            check("wait_s0_tready", PW'(bus.s0_tready), '0);
            check("wait_no_beat", PW'(bus.lii_out_p0_tvalid), '0);
            @(posedge aclk); #1;
        end
        bus.s1_tdata = 58'h0CCC_0000_0000_0003; bus.s1_tvalid = 1'b1;
        @(negedge aclk);
        check("wait_s0_tready_c10", PW'(bus.s0_tready), '0);
        @(posedge aclk); #1;
        bus.s1_tvalid = 1'b0;
        @(negedge aclk);
        check("pack_s0_tready", PW'(bus.s0_tready), PW'(1'b1));
        check("pack_no_beat_yet", PW'(bus.lii_out_p0_tvalid), '0);
        @(posedge aclk); #1;
        bus.s0_tvalid = 1'b0;
        begin
            item_t d;
            d.data = 64'h0DDD_0000_0000_0004; d.gap = 0;
            q1.push_back(d);
        end
        drive1();
        wait_drain();

        // Backpressure: one beat held, both holds full, then three back-to-back
        bus.lii_out_p0_tready = 1'b0;
        add_pair(64'h11, 64'h21, 0, 0);
        add_pair(64'h12, 64'h22, 0, 0);
        add_pair(64'h13, 64'h23, 0, 0);
        fork
            drive0();
            drive1();
        join_none
        repeat (6) begin @(posedge aclk); #1; end
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            check("stall_tvalid", PW'(bus.lii_out_p0_tvalid), PW'(1'b1));
            check("stall_tdata", bus.lii_out_p0_tdata, {14'd0, 58'h21, 56'h11});
            check("stall_ce", PW'(ce), '0);
        end
        @(posedge aclk); #1;
        bus.lii_out_p0_tready = 1'b1;
        hs = 0;
        repeat (3) begin
            @(negedge aclk);
            if (bus.lii_out_p0_tvalid && bus.lii_out_p0_tready) hs++;
        end
        check("back_to_back", PW'(hs), PW'(3));
        wait fork;
        wait_drain();

        // 100 pairs with random gaps and random downstream ready, from reset
        @(posedge aclk); #1; arst = 1'b1;
        @(posedge aclk); #1; arst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (k == 50)
                add_pair(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
            else
                add_pair(64'h00C0_FFEE_0000_0000 + 64'(k) * 64'h0000_0001_0000_0003,
                         64'h03FF_0000_0000_0000 - 64'(k) * 64'd7,
                         $urandom_range(0, 3), $urandom_range(0, 3));
        end
        rnd_rdy = 1'b1;
        fork
            drive0();
            drive1();
        join
        wait_drain();
        rnd_rdy = 1'b0;
        @(posedge aclk); #1;
        bus.lii_out_p0_tready = 1'b1;
        check("beat_cnt_100", PW'(beat_cnt), PW'(32'd100));

        // Reset while a beat is pending and s0 holds data
        bus.lii_out_p0_tready = 1'b0;
        add_pair(64'h5151, 64'h6161, 0, 0);
        begin
            item_t y;
            y.data = 64'h7777; y.gap = 0;
            q0.push_back(y);
        end
        fork
            drive0();
            drive1();
        join
        @(negedge aclk);
        check("pre_rst_tvalid", PW'(bus.lii_out_p0_tvalid), PW'(1'b1));
        arst = 1'b1;
        #1;
        check("arst_tvalid", PW'(bus.lii_out_p0_tvalid), '0);
        check("arst_beat_cnt", PW'(beat_cnt), '0);
        check("arst_ce", PW'(ce), '0);
        check("arst_s0_tready", PW'(bus.s0_tready), '0);
        exp_q.delete();
        @(posedge aclk); @(negedge aclk);
        arst = 1'b0;
        @(posedge aclk); #1;
        bus.lii_out_p0_tready = 1'b1;
        add_pair(64'h9A9A, 64'hBCBC, 0, 2);
        fork
            drive0();
            drive1();
        join
        wait_drain();
        check("post_rst_beat_cnt", PW'(beat_cnt), PW'(32'd1));

        // Counter wrap
        bus.lii_out_p0_tready = 1'b0;
        add_pair(64'h1234, 64'h5678, 0, 0);
        fork
            drive0();
            drive1();
        join
        @(posedge aclk); #1;
        force dut.beat_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.beat_cnt_q;
        check("wrap_preload", PW'(beat_cnt), PW'(32'hFFFF_FFFF));
        bus.lii_out_p0_tready = 1'b1;
        @(posedge aclk); #1;
        check("wrap_beat_cnt", PW'(beat_cnt), '0);
        wait_drain();

        repeat (3) @(posedge aclk);
        check("no_leftover", PW'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_pack2_tx.md
STREAM_PACK2_TX -- requirements
Module: stream_pack2_tx

Interface
REQ-001 Parameter PW, default 128, LII physical packing width in bits.
REQ-002 Parameter W0, default 56, width of logic stream 0 (lane at bits [W0-1:0]).
REQ-003 Parameter W1, default 58, width of logic stream 1 (lane at bits [W0+W1-1:W0]).
REQ-004 Parameter SRC_ID, default 8'h00, constant driven on lii_out_p0_src.
REQ-005 Parameter DST_ID, default 8'h01, constant driven on lii_out_p0_dst.
REQ-006 aclk  in  1  single clock; all state on rising edge.
REQ-007 arst  in  1  reset, asynchronous, active-high.
REQ-008 s0_tdata  in  W0  logic stream 0 data from HLS kernel.
REQ-009 s0_tvalid  in  1  stream 0 valid.
REQ-010 s0_tready  out  1  stream 0 ready.
REQ-011 s1_tdata  in  W1  logic stream 1 data from HLS kernel.
REQ-012 s1_tvalid  in  1  stream 1 valid.
REQ-013 s1_tready  out  1  stream 1 ready.
REQ-014 lii_out_p0_tdata  out  PW  packed LII beat.
REQ-015 lii_out_p0_tvalid  out  1  LII beat valid.
REQ-016 lii_out_p0_tready  in  1  LII downstream ready.
REQ-017 lii_out_p0_src  out  8  source tag, equals SRC_ID.
REQ-018 lii_out_p0_dst  out  8  destination tag, equals DST_ID.
REQ-019 beat_cnt  out  32  count of completed LII output handshakes.
REQ-020 ce  out  1  kernel clock enable.

Function
REQ-021 Elaboration shall fail if W0+W1 > PW.
REQ-022 Each input stream shall have a one-entry holding register with flag full0/full1; handshake s_i_tvalid&s_i_tready loads data and sets full_i.
REQ-023 Output stage shall be a single register (out_valid, out_data) driving lii_out_p0_tvalid/tdata directly (no combinational path input->output).
REQ-024 pack = full0 & full1 & (~out_valid | lii_out_p0_tready); on pack, out_data <= {zero pad, hold1, hold0}, out_valid <= 1, and full0/full1 clear unless reloaded the same cycle.
REQ-025 s_i_tready = ~full_i | pack; simultaneous pack and new input handshake on stream i shall leave full_i = 1 with the new data.
REQ-026 Streams shall be accepted independently; a beat on one stream shall wait indefinitely in its holding register for its partner; no beat pairing across reorder.
REQ-027 Output handshake without pack clears out_valid; with pack, out_valid stays 1 and out_data takes the new beat.
REQ-028 lii_out_p0_tdata and tvalid shall be stable while tvalid=1 and tready=0.
REQ-029 Pad bits [PW-1:W0+W1] shall always be 0.
REQ-030 Latency: both inputs accepted at edge N -> lii_out_p0_tvalid=1 after edge N+1; sustained throughput one beat per cycle when tready held 1.
REQ-031 beat_cnt increments by 1 on each lii_out_p0_tvalid&tready cycle; wraps 32'hFFFFFFFF -> 0.
REQ-032 ce = s0_tready & s1_tready (combinational); ce=0 whenever either holding register is full and cannot drain.
REQ-033 src/dst outputs are constant regardless of tvalid.

Reset
REQ-034 arst asserted shall immediately (asynchronously) clear full0, full1, out_valid, beat_cnt to 0; out_data to 0.
REQ-035 While arst=1: s0_tready=0, s1_tready=0, ce=0, lii_out_p0_tvalid=0.
REQ-036 Reset mid-transfer shall discard any held or pending beat; first post-reset output shall be from data accepted after deassertion.

Verification
REQ-037 Both valid same cycle, s0=56'h1, s1=58'h2, tready=1 -> tdata=128'h2_00000000000001 (s1 at bit 56), tvalid 2 edges later, beat_cnt=1.
REQ-038 s0 valid at cycle 0, s1 valid at cycle 10 -> s0_tready=0 cycles 1-10, single output beat after cycle 11, no beat earlier.
REQ-039 tready=0 for 20 cycles with both streams streaming -> one beat held stable, both holding regs full, ce=0; on tready=1, 3 beats emitted back-to-back in order.
REQ-040 100 random-gap beats per stream, random tready -> output sequence equals pairwise concatenation in order, pad bits 0, beat_cnt=100.
REQ-041 arst pulse while out_valid=1 and full0=1 -> tvalid drops same cycle, beat_cnt=0, next beat after reset carries only post-reset data.
REQ-042 Force beat_cnt to 32'hFFFFFFFF, complete one handshake -> beat_cnt=0.
